ln_spike_rate_accum: RTL and testbench
======================================

// Module: ln_spike_rate_accum
// PURPOSE
//  Downstream consumer of the layer-norm spike stage. Counts the spikes on each of the CH channels over
//  one block of T time steps, where one time step is one 16-bit spike vector. It then drains the
//  per-channel spike counts serially, one channel at a time, over a valid/ready handshake.
//  The counts are the rate-coded input to the next (classifier/pooling) stage.
// PARAMETERS
//  CH     16  spike channels per time step (width of spk_in)
//  T      30  time steps per block
//  CNT_W  5   count width; must satisfy 2**CNT_W > T
//  CH_W   4   channel index width; must satisfy 2**CH_W >= CH
// PORTS
//  clk           in   1         clock, rising edge
//  rst_n         in   1         reset, asynchronous, active-low
//  start         in   1         1-cycle pulse: begin new block (honoured only in IDLE)
//  blk_sel       in   3         block id, latched on accepted start
//  spk_in        in   CH        spike vector from layer norm, bit i = channel i
//  spk_in_valid  in   1         spk_in qualifier, one time step per valid cycle
//  out_cnt       out  CNT_W     spike count of channel out_ch
//  out_ch        out  CH_W      channel index of out_cnt
//  out_blk       out  3         latched blk_sel
//  out_valid     out  1         out_cnt/out_ch/out_blk valid
//  out_ready     in   1         downstream accepts when out_valid&out_ready
//  busy          out  1         high in ACCUM and DRAIN
//  frame_done    out  1         1-cycle pulse after last channel accepted
//  spk_ovf       out  1         sticky: spk_in_valid seen outside ACCUM
// BEHAVIOUR
//  Reset (async): state=IDLE; all counters, step, out_ch=0; out_cnt=0, out_blk=0;
//   out_valid=0, busy=0, frame_done=0, spk_ovf=0.
//  FSM IDLE -> ACCUM -> DRAIN -> DONE -> IDLE.
//  IDLE: start=1 -> clear cnt[0..CH-1] and step, latch blk_sel into out_blk, go ACCUM next cycle.
//   spk_in_valid in IDLE sets spk_ovf; data is discarded.
//  ACCUM: each spk_in_valid cycle: cnt[i] <= cnt[i] + spk_in[i] for all i; step <= step+1.
//   The valid with step==T-1 is counted, then the FSM goes to DRAIN (exactly T vectors counted).
//   Cycles with spk_in_valid=0 are stalls; there is no timeout.
//   Counts are unsigned and saturate at 2**CNT_W-1 (cannot be reached when the parameter rule holds).
//  DRAIN: out_valid=1; out_cnt=cnt[out_ch] (registered); out_ch starts at 0.
//   out_cnt/out_ch/out_blk are held stable while out_valid & !out_ready.
//   On handshake: out_ch increments. The next channel is presented the following cycle
//    (1 word/cycle throughput with out_ready held high).
//   Handshake with out_ch==CH-1 -> out_valid=0 next cycle, go DONE.
//  DONE: frame_done=1 for exactly one cycle, out_ch returns to 0, go IDLE.
//   A start in DONE is ignored.
//  start outside IDLE: ignored, with no state change.
//  spk_in_valid in DRAIN or DONE: sets spk_ovf and is discarded.
//   spk_ovf is cleared only by reset or by an accepted start.
//  busy = (state==ACCUM)|(state==DRAIN).
//  Latency: last accumulated vector -> first out_valid = 2 cycles.
//  Reset mid-operation: immediate return to IDLE with reset values; a partial block is lost.
// TESTING
//  1 Reset: assert rst_n=0 mid-ACCUM -> all outputs 0, IDLE; start again -> counts begin from 0.
//  2 start, blk_sel=3; 30 vectors of 16'hFFFF -> 16 words, out_cnt=30, out_ch=0..15, out_blk=3;
//    then one frame_done pulse.
//  3 start; 30 vectors, 16'h0001 on even steps and 16'h8000 on odd steps, with random
//    1-3 cycle valid gaps -> ch0=15, ch15=15, all others 0.
//  4 Backpressure: hold out_ready=0 for 5 cycles at ch7 -> out_cnt/out_ch held.
//    Then out_ready=1 -> ch8 presented on the next cycle, with no channel skipped or repeated.
//  5 spk_in_valid pulse during DRAIN -> spk_ovf=1 and drained counts unchanged;
//    next accepted start clears spk_ovf.
//  6 start pulse mid-ACCUM (step=12) -> ignored; block completes after 30 total vectors with correct counts.

Source files
------------

// File: rtl/ln_spike_rate_accum.sv
// Purpose: counts per-channel spikes over a block of T spike vectors, then drains one count per channel.
// Latency: last accumulated vector -> first out_valid is 2 cycles; drain runs at 1 word/cycle.
// Backpressure: out_cnt/out_ch/out_blk hold while out_valid & !out_ready; spk_in has no backpressure.
module ln_spike_rate_accum #(
  parameter int CH    = 16,
  parameter int T     = 30,
  parameter int CNT_W = 5,
  parameter int CH_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       blk_sel,
  input  logic [CH-1:0]    spk_in,
  input  logic             spk_in_valid,
  output logic [CNT_W-1:0] out_cnt,
  output logic [CH_W-1:0]  out_ch,
  output logic [2:0]       out_blk,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             frame_done,
  output logic             spk_ovf
);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(T - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(CH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt [CH];
  logic [CNT_W-1:0] step;
  logic [CH_W-1:0]  out_ch_inc;

  logic start_acc;
  logic last_vec;
  logic last_word;

  assign start_acc  = (state == IDLE) && start;
  assign last_vec   = (state == ACCUM) && spk_in_valid && (step == STEP_LAST);
  assign last_word  = (state == DRAIN) && out_valid && out_ready && (out_ch == CH_LAST);
  assign out_ch_inc = out_ch + CH_W'(1);

  // State register; reset drops any partial block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and state-decoded status outputs.
  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = ACCUM;
      end
      ACCUM: begin
        busy = 1'b1;
        if (last_vec) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (last_word) state_nxt = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Per-channel spike counters and time-step counter; counts saturate rather than wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step <= '0;
      for (int i = 0; i < CH; i++) cnt[i] <= '0;
    end else if (start_acc) begin
      step <= '0;
      for (int i = 0; i < CH; i++) cnt[i] <= '0;
    end else if ((state == ACCUM) && spk_in_valid) begin
      step <= step + CNT_W'(1);
      for (int i = 0; i < CH; i++) begin
        if (spk_in[i] && (cnt[i] != CNT_MAX)) cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

  // Registered drain port: first word loads one cycle into DRAIN, then one channel per handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_cnt   <= '0;
      out_ch    <= '0;
      out_blk   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) out_blk <= blk_sel;
        end
        DRAIN: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_cnt   <= cnt[out_ch];
          end else if (out_ready) begin
            if (out_ch == CH_LAST) begin
              out_valid <= 1'b0;
            end else begin
              out_ch  <= out_ch_inc;
              out_cnt <= cnt[out_ch_inc];
            end
          end
        end
        DONE: begin
          out_ch <= '0;
        end
        default: ;
      endcase
    end
  end

  // Sticky flag for spike vectors arriving when no block is accumulating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               spk_ovf <= 1'b0;
    else if (spk_in_valid && state != ACCUM)  spk_ovf <= 1'b1;
    else if (start_acc)                       spk_ovf <= 1'b0;
  end

endmodule

// File: tb/tb_ln_spike_rate_accum.sv
module tb_ln_spike_rate_accum;
  localparam int CH    = 16;
  localparam int T     = 30;
  localparam int CNT_W = 5;
  localparam int CH_W  = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [2:0]       blk_sel;
  logic [CH-1:0]    spk_in;
  logic             spk_in_valid;
  logic [CNT_W-1:0] out_cnt;
  logic [CH_W-1:0]  out_ch;
  logic [2:0]       out_blk;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             frame_done;
  logic             spk_ovf;

  ln_spike_rate_accum #(.CH(CH), .T(T), .CNT_W(CNT_W), .CH_W(CH_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .blk_sel(blk_sel),
    .spk_in(spk_in), .spk_in_valid(spk_in_valid),
    .out_cnt(out_cnt), .out_ch(out_ch), .out_blk(out_blk), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .frame_done(frame_done), .spk_ovf(spk_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]     ev;
    logic [15:0]     od;
    logic [2:0]      blk;
    int              max_gap;
    int              stall_ch;
    int              stall_len;
    int              ovf_ch;
    logic [3:0][4:0] exp_g;   // expected count, uniform within each group of 4 channels
  } row_t;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [15:0] sent [$];
  int          exp_cnt [CH];
  row_t        tbl [4];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: each channel's count is the number of sent vectors with that bit set, saturated.
  task automatic model_update();
    for (int i = 0; i < CH; i++) begin
      int n;
      n = 0;
      foreach (sent[k]) n += int'(sent[k][i]);
      exp_cnt[i] = (n > CMAX) ? CMAX : n;
    end
  endtask

  // Start a block and feed T vectors: fixed even/odd pattern or random, optional gaps and a stray start.
  task automatic run_block(input logic [2:0] blk, input int rnd, input logic [15:0] ev,
                           input logic [15:0] od, input int max_gap, input int start_at,
                           input string tag);
    sent.delete();
    blk_sel = blk;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    blk_sel = ~blk;
    chk({tag, " busy after start"}, int'(busy), 1);
    chk({tag, " ovf cleared by start"}, int'(spk_ovf), 0);
    for (int s = 0; s < T; s++) begin
      int          gap;
      logic [15:0] v;
      gap = (max_gap > 0) ? int'($urandom_range(1, max_gap)) : 0;
      repeat (gap) tick();
      v = (rnd != 0) ? 16'($urandom) : ((s % 2) != 0 ? od : ev);
      spk_in       = v;
      spk_in_valid = 1'b1;
      if (s == start_at) start = 1'b1;
      sent.push_back(v);
      tick();
      spk_in_valid = 1'b0;
      start        = 1'b0;
    end
    chk({tag, " valid low 1 cycle after last vec"}, int'(out_valid), 0);
    chk({tag, " busy entering drain"}, int'(busy), 1);
  endtask

  // Drain all channels against exp_cnt, with optional stall, random ready, or stray spike during drain.
  task automatic drain(input logic [2:0] blk, input int stall_ch, input int stall_len,
                       input int ovf_ch, input int rnd_ready, input string tag);
    int               seen, guard, stalled, vcyc, wait_cyc;
    bit               ovf_done, rdy;
    logic [CNT_W-1:0] hold_cnt;
    logic [CH_W-1:0]  hold_ch;
    seen = 0; guard = 0; stalled = 0; vcyc = 0; wait_cyc = 0; ovf_done = 0;
    hold_cnt = '0; hold_ch = '0;
    out_ready = 1'b1;
    while (seen < CH && guard < 400) begin
      guard++;
      spk_in_valid = 1'b0;
      if (!ovf_done && ovf_ch == seen) begin
        spk_in       = 16'hFFFF;
        spk_in_valid = 1'b1;
        ovf_done     = 1;
      end
      if (!out_valid) begin
        if (vcyc == 0) wait_cyc++;
        out_ready = 1'b1;
      end else begin
        vcyc++;
        rdy = (rnd_ready != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        if (seen == stall_ch) begin
          if (stalled == 0) begin
            hold_cnt = out_cnt;
            hold_ch  = out_ch;
          end else begin
            chk($sformatf("%s stall hold cnt %0d", tag, stalled), int'(out_cnt), int'(hold_cnt));
            chk($sformatf("%s stall hold ch %0d", tag, stalled), int'(out_ch), int'(hold_ch));
          end
          if (stalled < stall_len) rdy = 1'b0;
          stalled++;
        end
        out_ready = rdy;
        if (rdy) begin
          chk($sformatf("%s word%0d out_ch", tag, seen), int'(out_ch), seen);
          chk($sformatf("%s ch%0d out_cnt", tag, seen), int'(out_cnt), exp_cnt[seen]);
          chk($sformatf("%s ch%0d out_blk", tag, seen), int'(out_blk), int'(blk));
          seen++;
        end
      end
      tick();
    end
    spk_in_valid = 1'b0;
    out_ready    = 1'b1;
    chk({tag, " words drained"}, seen, CH);
    chk({tag, " first-word latency"}, wait_cyc, 1);
    if (rnd_ready == 0)
      chk({tag, " drain cycles"}, vcyc, CH + ((stall_ch >= 0) ? stall_len : 0));
    chk({tag, " frame_done"}, int'(frame_done), 1);
    chk({tag, " valid low in done"}, int'(out_valid), 0);
    chk({tag, " spk_ovf"}, int'(spk_ovf), (ovf_ch >= 0) ? 1 : 0);
    start   = 1'b1;
    blk_sel = ~blk;
    tick();
    start   = 1'b0;
    chk({tag, " frame_done one cycle"}, int'(frame_done), 0);
    chk({tag, " out_ch back to 0"}, int'(out_ch), 0);
    chk({tag, " busy after done"}, int'(busy), 0);
    tick();
    chk({tag, " start in done ignored"}, int'(busy), 0);
    chk({tag, " out_blk kept"}, int'(out_blk), int'(blk));
  endtask

  initial begin
    tbl[0] = '{16'hFFFF, 16'hFFFF, 3'd3, 0, -1, 0, -1, {5'd30, 5'd30, 5'd30, 5'd30}};
    tbl[1] = '{16'h00FF, 16'h0F0F, 3'd1, 2,  7, 5, -1, {5'd0,  5'd15, 5'd15, 5'd30}};
    tbl[2] = '{16'hF000, 16'hFFF0, 3'd6, 0, -1, 0,  9, {5'd30, 5'd15, 5'd15, 5'd0}};
    tbl[3] = '{16'h0000, 16'h0000, 3'd7, 1,  3, 2, -1, {5'd0,  5'd0,  5'd0,  5'd0}};

    rst_n = 1'b0; start = 1'b0; blk_sel = '0; spk_in = '0; spk_in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) tick();
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset out_cnt", int'(out_cnt), 0);
    chk("reset out_ch", int'(out_ch), 0);
    chk("reset frame_done", int'(frame_done), 0);
    chk("reset spk_ovf", int'(spk_ovf), 0);
    rst_n = 1'b1;
    tick();

    // Stray vector in IDLE raises the sticky flag without starting anything.
    spk_in = 16'hFFFF; spk_in_valid = 1'b1;
    tick();
    spk_in_valid = 1'b0;
    tick();
    chk("idle vec sets spk_ovf", int'(spk_ovf), 1);
    chk("idle vec no busy", int'(busy), 0);

    // Partial block interrupted by reset, then a clean block must count from zero.
    blk_sel = 3'd5; start = 1'b1;
    tick();
    start = 1'b0;
    for (int s = 0; s < 10; s++) begin
      spk_in = 16'hFFFF; spk_in_valid = 1'b1;
      tick();
    end
    spk_in_valid = 1'b0;
    chk("mid-accum busy", int'(busy), 1);
    chk("mid-accum out_blk", int'(out_blk), 5);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset busy", int'(busy), 0);
    chk("async reset out_blk", int'(out_blk), 0);
    chk("async reset out_valid", int'(out_valid), 0);
    chk("async reset spk_ovf", int'(spk_ovf), 0);
    tick();
    rst_n = 1'b1;
    tick();
    run_block(3'd2, 0, 16'h0003, 16'h0003, 0, -1, "post-reset");
    for (int i = 0; i < CH; i++) exp_cnt[i] = (i < 2) ? 30 : 0;
    drain(3'd2, -1, 0, -1, 0, "post-reset");

    // Table of fixed-pattern blocks with their expected per-group counts.
    for (int r = 0; r < 4; r++) begin
      string tag;
      tag = $sformatf("row%0d", r);
      run_block(tbl[r].blk, 0, tbl[r].ev, tbl[r].od, tbl[r].max_gap, -1, tag);
      for (int i = 0; i < CH; i++) exp_cnt[i] = int'(tbl[r].exp_g[i / 4]);
      drain(tbl[r].blk, tbl[r].stall_ch, tbl[r].stall_len, tbl[r].ovf_ch, 0, tag);
    end

    // Alternating ch0/ch15 spikes with random 1-3 cycle gaps.
    run_block(3'd4, 0, 16'h0001, 16'h8000, 3, -1, "alt");
    for (int i = 0; i < CH; i++) exp_cnt[i] = (i == 0 || i == CH - 1) ? 15 : 0;
    drain(3'd4, -1, 0, -1, 0, "alt");

    // Stray start at step 12 must not restart the block.
    run_block(3'd2, 1, 16'h0, 16'h0, 0, 12, "midstart");
    model_update();
    drain(3'd2, -1, 0, -1, 0, "midstart");

    // Random vectors, gaps, block ids and downstream readiness against the reference model.
    for (int b = 0; b < 4; b++) begin
      logic [2:0] blk;
      string      tag;
      blk = 3'($urandom);
      tag = $sformatf("rnd%0d", b);
      run_block(blk, 1, 16'h0, 16'h0, 2, -1, tag);
      model_update();
      drain(blk, -1, 0, -1, 1, tag);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
